// File: rtl/div_if.sv
// ============================================================================
// Module : div_if
// Brief  : Request/result bundle between the execute stage and div_unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface div_if;
    logic        start;
    logic        signed_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic        result_valid;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, signed_div, a, b, cancel,
        input  busy, result_valid, hi, lo
    );

    modport slave (
        input  start, signed_div, a, b, cancel,
        output busy, result_valid, hi, lo
    );
endinterface

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
// Module : div_unit
// Brief  : Iterative radix-2 restoring 32-bit DIV/DIVU, one bit per clock.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module div_unit (
    input  logic  clk,
    input  logic  rst,
    div_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [4:0] C_LAST_ITER = 5'd31;

    logic [1:0]  r_state;
    logic [4:0]  r_count;
    logic [32:0] r_rem;
    logic [31:0] r_dividend;   // shifts out dividend bits, shifts in quotient bits
    logic [31:0] r_divisor;
    logic        r_signed;
    logic        r_q_neg;
    logic        r_r_neg;
    logic        r_valid;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_shift_rem;
    logic [32:0] w_trial;

    assign w_abs_a     = (bus.signed_div && bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
    assign w_abs_b     = (bus.signed_div && bus.b[31]) ? (~bus.b + 32'd1) : bus.b;
    assign w_shift_rem = {r_rem[31:0], r_dividend[31]};
    assign w_trial     = w_shift_rem - {1'b0, r_divisor};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_count    <= 5'd0;
            r_rem      <= 33'd0;
            r_dividend <= 32'd0;
            r_divisor  <= 32'd0;
            r_signed   <= 1'b0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_valid    <= 1'b0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start && !bus.cancel) begin
                        r_dividend <= w_abs_a;
                        r_divisor  <= w_abs_b;
                        r_signed   <= bus.signed_div;
                        r_q_neg    <= bus.a[31] ^ bus.b[31];
                        r_r_neg    <= bus.a[31];
                        r_rem      <= 33'd0;
                        r_count    <= 5'd0;
                        r_state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (bus.cancel) begin
                        r_state <= S_IDLE;
                    end else begin
                        // Restore by simply keeping the shifted value when the trial goes negative
                        r_rem      <= w_trial[32] ? w_shift_rem : w_trial;
                        r_dividend <= {r_dividend[30:0], ~w_trial[32]};
                        r_count    <= r_count + 5'd1;
                        if (r_count == C_LAST_ITER) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (!bus.cancel) begin
                        r_lo    <= (r_signed && r_q_neg) ? (~r_dividend + 32'd1) : r_dividend;
                        r_hi    <= (r_signed && r_r_neg) ? (~r_rem[31:0] + 32'd1) : r_rem[31:0];
                        r_valid <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy         = (r_state != S_IDLE);
    assign bus.result_valid = r_valid;
    assign bus.hi           = r_hi;
    assign bus.lo           = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// Module : tb_div_unit
// Brief  : Directed and random checks of div_unit against an arithmetic model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_div_unit;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    div_if bus ();

    div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: divide magnitudes with native arithmetic, then apply the sign rules.
    function automatic void model(input logic sd, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        logic [31:0] ma, mb, mq, mr;
        ma = (sd && a[31]) ? -a : a;
        mb = (sd && b[31]) ? -b : b;
        if (mb == 32'd0) begin
            mq = 32'hFFFF_FFFF;
            mr = ma;
        end else begin
            mq = ma / mb;
            mr = ma % mb;
        end
        q = (sd && (a[31] ^ b[31])) ? -mq : mq;
        r = (sd && a[31]) ? -mr : mr;
    endfunction

    // Issues one request and follows it for 33 cycles; returns just after the valid edge.
    // inject > 0 pulses a second start with other operands during that cycle of CALC.
    task automatic run_op(input string tag, input logic sd, input logic [31:0] a,
                          input logic [31:0] b, input int inject);
        logic [31:0] eq, er;
        int early, busy_cnt;
        model(sd, a, b, eq, er);
        bus.start = 1'b1;
        bus.signed_div = sd;
        bus.a = a;
        bus.b = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
        bus.signed_div = ~sd;
        early = 0;
        busy_cnt = 0;
        for (int i = 1; i <= 33; i++) begin
            bus.start = (i == inject);
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (i < 33) begin
                if (bus.result_valid === 1'b1) early++;
                if (bus.busy === 1'b1) busy_cnt++;
            end
        end
        chk({tag, "_early_valid"}, early, 0);
        chk({tag, "_busy_cycles"}, busy_cnt, 32);
        chk({tag, "_valid"}, {31'd0, bus.result_valid}, 32'd1);
        chk({tag, "_busy_end"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_lo"}, bus.lo, eq);
        chk({tag, "_hi"}, bus.hi, er);
    endtask

    initial begin
        logic [31:0] prev_hi, prev_lo, ra, rb;
        logic        rsd;
        int          vcount;
        total = 0;
        bad = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.signed_div = 1'b0;
        bus.a = 32'd0;
        bus.b = 32'd0;
        bus.cancel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_valid", {31'd0, bus.result_valid}, 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 0);
        chk("divu_100_7_lo_lit", bus.lo, 32'd14);
        chk("divu_100_7_hi_lit", bus.hi, 32'd2);
        @(posedge clk); #1;
        chk("valid_falls", {31'd0, bus.result_valid}, 32'd0);
        chk("hold_lo", bus.lo, 32'd14);

        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        chk("div_m7_2_lo_lit", bus.lo, 32'hFFFF_FFFD);
        chk("div_m7_2_hi_lit", bus.hi, 32'hFFFF_FFFF);
        run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        chk("div_ovf_lo_lit", bus.lo, 32'h8000_0000);
        chk("div_ovf_hi_lit", bus.hi, 32'd0);
        run_op("divu_5_0", 1'b0, 32'd5, 32'd0, 0);
        chk("divu_5_0_lo_lit", bus.lo, 32'hFFFF_FFFF);
        chk("divu_5_0_hi_lit", bus.hi, 32'd5);
        run_op("div_m9_0", 1'b1, 32'hFFFF_FFF7, 32'd0, 0);

        // Cancel at iteration 10 keeps the previous result
        @(posedge clk); #1;
        prev_hi = bus.hi;
        prev_lo = bus.lo;
        bus.start = 1'b1;
        bus.signed_div = 1'b0;
        bus.a = 32'd1000;
        bus.b = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        bus.cancel = 1'b1;
        @(posedge clk); #1;
        bus.cancel = 1'b0;
        chk("cancel_busy", {31'd0, bus.busy}, 32'd0);
        chk("cancel_valid", {31'd0, bus.result_valid}, 32'd0);
        chk("cancel_hi", bus.hi, prev_hi);
        chk("cancel_lo", bus.lo, prev_lo);
        run_op("after_cancel_9_4", 1'b0, 32'd9, 32'd4, 0);
        chk("after_cancel_lo_lit", bus.lo, 32'd2);
        chk("after_cancel_hi_lit", bus.hi, 32'd1);

        // Cancel wins over start while idle
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.cancel = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.cancel = 1'b0;
        chk("cancel_prio_busy", {31'd0, bus.busy}, 32'd0);

        // A start pulse during CALC must not disturb the running divide
        run_op("start_in_calc", 1'b0, 32'd20, 32'd6, 5);

        // Random back-to-back operations
        for (int n = 0; n < 24; n++) begin
            rsd = 1'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'($urandom_range(1, 15));
                1: rb = 32'd0;
                2: rb = -32'($urandom_range(1, 1000));
                default: rb = $urandom;
            endcase
            run_op($sformatf("rand%0d", n), rsd, ra, rb, 0);
        end

        // Reset at iteration 20
        bus.start = 1'b1;
        bus.signed_div = 1'b0;
        bus.a = 32'd12345;
        bus.b = 32'd11;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst_hi", bus.hi, 32'd0);
        chk("midrst_lo", bus.lo, 32'd0);
        chk("midrst_valid", {31'd0, bus.result_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.result_valid === 1'b1 || bus.busy === 1'b1) vcount++;
        end
        chk("midrst_no_valid", vcount, 0);
        run_op("after_rst", 1'b1, 32'd77, 32'hFFFF_FFFB, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
